// File: rtl/dcache_pkg.sv
// Shared field widths and FSM state encoding for the direct-mapped data cache.
package dcache_pkg;

    localparam int unsigned NUM_LINES  = 8;
    localparam int unsigned ADDR_W     = 8;
    localparam int unsigned TAG_W      = 3;
    localparam int unsigned INDEX_W    = 3;
    localparam int unsigned OFFSET_W   = 2;
    localparam int unsigned BLOCK_W    = 32;
    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned MEM_ADDR_W = TAG_W + INDEX_W;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WRITE_BACK = 2'd1,
        MEM_READ   = 2'd2,
        UPDATE     = 2'd3
    } state_e;

endpackage

// File: rtl/dcache_line_array.sv
// Line storage: valid/dirty/tag/data per line, combinational read port,
// synchronous byte merge or whole-block fill, async clear of valid/dirty only.
module dcache_line_array
    import dcache_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [INDEX_W-1:0]  index_i,
    output logic                valid_o,
    output logic                dirty_o,
    output logic [TAG_W-1:0]    tag_o,
    output logic [BLOCK_W-1:0]  data_o,
    input  logic                byte_we_i,
    input  logic [OFFSET_W-1:0] offset_i,
    input  logic [BYTE_W-1:0]   byte_i,
    input  logic                fill_we_i,
    input  logic [TAG_W-1:0]    fill_tag_i,
    input  logic [BLOCK_W-1:0]  fill_data_i
);

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [BLOCK_W-1:0]   data_q [NUM_LINES];

    // Read port for the line selected by the current index
    always_comb begin
        valid_o = valid_q[index_i];
        dirty_o = dirty_q[index_i];
        tag_o   = tag_q[index_i];
        data_o  = data_q[index_i];
    end

    // Line status bits; a fill leaves the line clean, a byte merge dirties it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_we_i) begin
            valid_q[index_i] <= 1'b1;
            dirty_q[index_i] <= 1'b0;
        end else if (byte_we_i) begin
            dirty_q[index_i] <= 1'b1;
        end
    end

    // Tag and data payload; deliberately not reset
    always_ff @(posedge clk) begin
        if (fill_we_i) begin
            tag_q[index_i]  <= fill_tag_i;
            data_q[index_i] <= fill_data_i;
        end else if (byte_we_i) begin
            data_q[index_i][{offset_i, 3'b000} +: BYTE_W] <= byte_i;
        end
    end

endmodule

// File: rtl/dcache_direct_mapped.sv
// Direct-mapped write-back/write-allocate byte cache in front of a
// block-organised data memory; stalls the CPU via busywait during misses.
module dcache_direct_mapped
    import dcache_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  read,
    input  logic                  write,
    input  logic [ADDR_W-1:0]     address,
    input  logic [BYTE_W-1:0]     writedata,
    output logic [BYTE_W-1:0]     readdata,
    output logic                  busywait,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [MEM_ADDR_W-1:0] mem_address,
    output logic [BLOCK_W-1:0]    mem_writedata,
    input  logic [BLOCK_W-1:0]    mem_readdata,
    input  logic                  mem_busywait
);

    logic [TAG_W-1:0]    addr_tag;
    logic [INDEX_W-1:0]  addr_index;
    logic [OFFSET_W-1:0] addr_offset;

    logic                line_valid;
    logic                line_dirty;
    logic [TAG_W-1:0]    line_tag;
    logic [BLOCK_W-1:0]  line_data;

    logic                access_c;
    logic                hit_c;
    logic                byte_we;
    logic                fill_we;

    state_e              state_q, state_d;
    logic                wb_armed_q, wb_armed_d;

    assign addr_tag      = address[7:5];
    assign addr_index    = address[4:2];
    assign addr_offset   = address[1:0];
    assign access_c      = read ^ write;
    assign hit_c         = line_valid && (line_tag == addr_tag);
    assign mem_writedata = line_data;

    dcache_line_array u_lines (
        .clk         (clock),
        .rst_n       (reset),
        .index_i     (addr_index),
        .valid_o     (line_valid),
        .dirty_o     (line_dirty),
        .tag_o       (line_tag),
        .data_o      (line_data),
        .byte_we_i   (byte_we),
        .offset_i    (addr_offset),
        .byte_i      (writedata),
        .fill_we_i   (fill_we),
        .fill_tag_i  (addr_tag),
        .fill_data_i (mem_readdata)
    );

    // State register; wb_armed_q blocks leaving WRITE_BACK in its entry cycle
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            wb_armed_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wb_armed_q <= wb_armed_d;
        end
    end

    // Next-state, memory handshake, CPU stall and line-array write controls
    always_comb begin
        state_d     = state_q;
        wb_armed_d  = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_address = '0;
        byte_we     = 1'b0;
        fill_we     = 1'b0;
        readdata    = '0;
        busywait    = access_c && !((state_q == IDLE) && hit_c);

        unique case (state_q)
            IDLE: begin
                readdata = line_data[{addr_offset, 3'b000} +: BYTE_W];
                if (access_c) begin
                    if (hit_c) begin
                        byte_we = write;
                    end else if (line_dirty) begin
                        state_d = WRITE_BACK;
                    end else begin
                        state_d = MEM_READ;
                    end
                end
            end
            WRITE_BACK: begin
                mem_write   = 1'b1;
                mem_address = {line_tag, addr_index};
                wb_armed_d  = 1'b1;
                if (wb_armed_q && !mem_busywait) begin
                    state_d = MEM_READ;
                end
            end
            MEM_READ: begin
                mem_read    = 1'b1;
                mem_address = address[7:2];
                if (!mem_busywait) begin
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                fill_we = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dcache_direct_mapped.sv
// Directed bench for dcache_direct_mapped with a small latency-modelled data memory.
module tb_dcache_direct_mapped;

    localparam int LAT     = 2;
    localparam int TIMEOUT = 100;

    logic        clock;
    logic        reset;
    logic        read;
    logic        write;
    logic [7:0]  address;
    logic [7:0]  writedata;
    logic [7:0]  readdata;
    logic        busywait;
    logic        mem_read;
    logic        mem_write;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_busywait;

    int checks = 0;
    int errors = 0;

    dcache_direct_mapped dut (
        .clock         (clock),
        .reset         (reset),
        .read          (read),
        .write         (write),
        .address       (address),
        .writedata     (writedata),
        .readdata      (readdata),
        .busywait      (busywait),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_busywait  (mem_busywait)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Data memory model: each request stalls LAT+1 cycles, completes on the edge
    // where busywait is low, readdata registered at completion.
    logic [31:0] mem [64];
    logic [31:0] rdata_q;
    logic [1:0]  kind;
    logic [1:0]  ck;
    int          cnt;
    int          rd_txn, wr_txn, traffic, both_high;
    logic [5:0]  last_rd_addr, last_wr_addr;
    logic [31:0] last_wr_data;

    assign kind         = {mem_read, mem_write};
    assign mem_busywait = (kind != 2'b00) && !((ck == kind) && (cnt >= LAT));
    assign mem_readdata = rdata_q;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        rdata_q = 32'h0; ck = 2'b00; cnt = 0;
        rd_txn = 0; wr_txn = 0; traffic = 0; both_high = 0;
        last_rd_addr = 6'h3f; last_wr_addr = 6'h3f; last_wr_data = 32'hxxxxxxxx;
    end

    always @(posedge clock) begin
        if (kind != 2'b00 && !mem_busywait) begin
            if (mem_write) begin
                mem[mem_address] <= mem_writedata;
                wr_txn       <= wr_txn + 1;
                last_wr_addr <= mem_address;
                last_wr_data <= mem_writedata;
            end else begin
                rdata_q      <= mem[mem_address];
                rd_txn       <= rd_txn + 1;
                last_rd_addr <= mem_address;
            end
        end
        if (kind == 2'b00) begin
            ck <= 2'b00; cnt <= 0;
        end else if (kind != ck) begin
            ck <= kind; cnt <= 1;
        end else begin
            cnt <= cnt + 1;
        end
        if (mem_read || mem_write) traffic <= traffic + 1;
        if (mem_read && mem_write) both_high <= both_high + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one CPU request, wait (bounded) for busywait low, sample readdata,
    // then let one more edge pass so stores merge.
    task automatic access(input logic r, input logic w, input logic [7:0] a,
                          input logic [7:0] wd, output int stalls, output logic [7:0] rd);
        read = r; write = w; address = a; writedata = wd;
        #1;
        stalls = 0;
        while (busywait && stalls < TIMEOUT) begin
            @(posedge clock); #1;
            stalls++;
        end
        chk("no_timeout", 32'(busywait), 32'd0);
        rd = readdata;
        @(posedge clock); #1;
        read = 1'b0; write = 1'b0;
    endtask

    int         st;
    logic [7:0] rd;
    int         rd0, wr0, tr0;

    initial begin
        reset = 1'b0; read = 1'b0; write = 1'b0; address = 8'h00; writedata = 8'h00;
        #1;
        chk("rst_busywait", 32'(busywait), 32'd0);
        chk("rst_mem_read", 32'(mem_read), 32'd0);
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b1;

        // 1: cold read
        rd0 = rd_txn; wr0 = wr_txn;
        access(1'b1, 1'b0, 8'h05, 8'h00, st, rd);
        chk("t1_stalls", 32'(st), 32'd5);
        chk("t1_rdata", 32'(rd), 32'h00);
        chk("t1_rd_txn", 32'(rd_txn - rd0), 32'd1);
        chk("t1_wr_txn", 32'(wr_txn - wr0), 32'd0);
        chk("t1_rd_addr", 32'(last_rd_addr), 32'h01);

        // 2: write hit, then read back
        tr0 = traffic;
        access(1'b0, 1'b1, 8'h05, 8'hAB, st, rd);
        chk("t2_wr_stalls", 32'(st), 32'd0);
        chk("t2_traffic", 32'(traffic - tr0), 32'd0);
        access(1'b1, 1'b0, 8'h05, 8'h00, st, rd);
        chk("t2_rd05_stalls", 32'(st), 32'd0);
        chk("t2_rd05", 32'(rd), 32'hAB);
        access(1'b1, 1'b0, 8'h04, 8'h00, st, rd);
        chk("t2_rd04", 32'(rd), 32'h00);
        chk("t2_traffic_total", 32'(traffic - tr0), 32'd0);

        // 3: dirty eviction of index 1
        rd0 = rd_txn; wr0 = wr_txn;
        access(1'b1, 1'b0, 8'h25, 8'h00, st, rd);
        chk("t3_stalls", 32'(st), 32'd8);
        chk("t3_wr_txn", 32'(wr_txn - wr0), 32'd1);
        chk("t3_wr_addr", 32'(last_wr_addr), 32'h01);
        chk("t3_wr_data", last_wr_data, 32'h0000AB00);
        chk("t3_rd_addr", 32'(last_rd_addr), 32'h09);
        chk("t3_rdata", 32'(rd), 32'h00);
        access(1'b1, 1'b0, 8'h05, 8'h00, st, rd);
        chk("t3_reread_stalls", 32'(st), 32'd5);
        chk("t3_reread_addr", 32'(last_rd_addr), 32'h01);
        chk("t3_reread", 32'(rd), 32'hAB);

        // 4: write miss on a clean invalid line, then prove it is dirty
        rd0 = rd_txn; wr0 = wr_txn;
        access(1'b0, 1'b1, 8'h42, 8'h5A, st, rd);
        chk("t4_stalls", 32'(st), 32'd5);
        chk("t4_rd_txn", 32'(rd_txn - rd0), 32'd1);
        chk("t4_rd_addr", 32'(last_rd_addr), 32'h10);
        chk("t4_wr_txn", 32'(wr_txn - wr0), 32'd0);
        access(1'b1, 1'b0, 8'h42, 8'h00, st, rd);
        chk("t4_rd_stalls", 32'(st), 32'd0);
        chk("t4_rd", 32'(rd), 32'h5A);
        access(1'b1, 1'b0, 8'h02, 8'h00, st, rd);
        chk("t4_evict_stalls", 32'(st), 32'd8);
        chk("t4_evict_addr", 32'(last_wr_addr), 32'h10);
        chk("t4_evict_data", last_wr_data, 32'h005A0000);

        // 5: reset during MEM_READ
        read = 1'b1; address = 8'h65;
        #1;
        chk("t5_busy_miss", 32'(busywait), 32'd1);
        @(posedge clock); #1;
        chk("t5_in_mem_read", 32'(mem_read), 32'd1);
        chk("t5_mem_addr", 32'(mem_address), 32'h19);
        reset = 1'b0;
        #1;
        chk("t5_rst_mem_read", 32'(mem_read), 32'd0);
        chk("t5_rst_mem_write", 32'(mem_write), 32'd0);
        chk("t5_rst_busy_held", 32'(busywait), 32'd1);
        read = 1'b0;
        #1;
        chk("t5_rst_busy_idle", 32'(busywait), 32'd0);
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b1;
        rd0 = rd_txn;
        access(1'b1, 1'b0, 8'h05, 8'h00, st, rd);
        chk("t5_miss_stalls", 32'(st), 32'd5);
        chk("t5_miss_rd_txn", 32'(rd_txn - rd0), 32'd1);
        chk("t5_miss_rd", 32'(rd), 32'hAB);

        // 6: read and write together is no access
        tr0 = traffic;
        read = 1'b1; write = 1'b1; address = 8'h05; writedata = 8'hFF;
        #1;
        chk("t6_busy", 32'(busywait), 32'd0);
        repeat (3) @(posedge clock);
        #1;
        chk("t6_busy_later", 32'(busywait), 32'd0);
        chk("t6_traffic", 32'(traffic - tr0), 32'd0);
        read = 1'b0; write = 1'b0;
        access(1'b1, 1'b0, 8'h05, 8'h00, st, rd);
        chk("t6_line_stalls", 32'(st), 32'd0);
        chk("t6_line_data", 32'(rd), 32'hAB);

        chk("never_both_high", 32'(both_high), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
